echo_requester: RTL and testbench
=================================

ECHO_REQUESTER -- requirements
Module: echo_requester

Interface
REQ-001 Parameter: DEPTH, 4, max outstanding requests (power of two, 2..16).
REQ-002 CLK  input  1  clock; all state changes on rising edge.
REQ-003 nRST  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  single-cycle pulse; begins a run.
REQ-005 count  input  8  number of requests in the run; sampled on start.
REQ-006 base_v  input  32  payload base value; sampled on start.
REQ-007 request$say__ENA  output  1  request issue strobe.
REQ-008 request$say_meth  output  32  request method index.
REQ-009 request$say_v  output  32  request payload.
REQ-010 request$say__RDY  input  1  echo side can accept a request.
REQ-011 indication$heard__ENA  input  1  response strobe.
REQ-012 indication$heard_meth  input  32  response method.
REQ-013 indication$heard_v  input  32  response payload.
REQ-014 indication$heard__RDY  output  1  requester can accept a response.
REQ-015 busy  output  1  run in progress.
REQ-016 done  output  1  run complete; held until next start or reset.
REQ-017 pass_count  output  8  responses matching expectation.
REQ-018 fail_count  output  8  responses mismatching expectation.

Function
REQ-019 States: IDLE, RUN, DONE; busy = (state==RUN), done = (state==DONE).
REQ-020 IDLE or DONE + start: latch count and base_v, clear issued/received/pass/fail counters, clear expectation FIFO, go to RUN next cycle.
REQ-021 start while in RUN is ignored.
REQ-022 Request k (k = 0..count-1): meth = k zero-extended, v = base_v + k (mod 2^32).
REQ-023 request$say__ENA = RUN && issued < count && FIFO not full && request$say__RDY; combinational, never asserted without RDY.
REQ-024 On each issue: push {meth, v} into expectation FIFO and increment issued, same edge.
REQ-025 indication$heard__RDY = RUN && FIFO not empty; responses offered while RDY low are not consumed and leave no state change.
REQ-026 On accepted response (ENA && RDY): pop FIFO head; if meth and v both equal head, pass_count+1, else fail_count+1; received+1.
REQ-027 Issue and accept in the same cycle: push and pop both take effect; occupancy unchanged; a full FIFO with a simultaneous pop still blocks issue that cycle (issue gating uses pre-pop occupancy).
REQ-028 Outstanding requests (issued - received) never exceed DEPTH.
REQ-029 RUN -> DONE on the edge where received reaches count; with count = 0, RUN -> DONE on the first RUN cycle, no requests issued.
REQ-030 Counters 8-bit, no wrap possible since count <= 255.
REQ-031 Response latency is unbounded; block waits indefinitely in RUN.

Reset
REQ-032 nRST low at an edge: state IDLE, FIFO empty, issued/received/pass_count/fail_count = 0, latched count/base_v = 0.
REQ-033 Reset values of outputs: request$say__ENA 0, request$say_meth 0, request$say_v 0, indication$heard__RDY 0, busy 0, done 0, pass_count 0, fail_count 0.
REQ-034 Reset mid-run abandons the run; outstanding responses arriving after reset are not accepted (heard__RDY low in IDLE).

Structure
REQ-035 Shared package: state enumeration (IDLE, RUN, DONE) and the {meth, v} expectation record type (64 bits).
REQ-036 One sub-module: echo_expect_fifo, DEPTH-entry synchronous FIFO of the record type with push, pop, full, empty, head; simultaneous push/pop supported.

Verification
REQ-037 count=3, base_v=0x10, echo model with 2-cycle delay -> requests (0,0x10),(1,0x11),(2,0x12); pass_count=3, fail_count=0, done=1.
REQ-038 count=2, model returns v+1 on the second response -> pass_count=1, fail_count=1, done=1.
REQ-039 count=10, model never responds -> exactly DEPTH=4 requests issued, then ENA stays 0, busy=1, heard__RDY=1.
REQ-040 request$say__RDY held 0 for 5 cycles mid-run -> no ENA during those cycles; payload sequence continues unbroken afterward.
REQ-041 count=0 start -> done=1 two cycles after start, no ENA, counts 0.
REQ-042 count=6, nRST low after 3 issues -> all outputs at reset values next cycle; a new start then runs cleanly to pass_count=6.

Source files
------------

// File: rtl/echo_requester_pkg.sv
// Shared types for the echo requester: FSM states and the {meth, v} record
// stored in the expectation FIFO.
package echo_requester_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] meth;
    logic [31:0] v;
  } expect_t;

  // Request k of a run carries meth = k and v = base + k (wrapping).
  function automatic expect_t make_expect(input logic [7:0] k, input logic [31:0] base);
    expect_t e;
    e.meth = {24'd0, k};
    e.v    = base + {24'd0, k};
    return e;
  endfunction

endpackage

// File: rtl/echo_requester_if.sv
// Request/indication handshake between the requester (master) and the echo side (slave).
interface echo_requester_if;
  logic        request_say__ENA;
  logic [31:0] request_say_meth;
  logic [31:0] request_say_v;
  logic        request_say__RDY;
  logic        indication_heard__ENA;
  logic [31:0] indication_heard_meth;
  logic [31:0] indication_heard_v;
  logic        indication_heard__RDY;

  modport master (
    output request_say__ENA, request_say_meth, request_say_v,
    input  request_say__RDY,
    input  indication_heard__ENA, indication_heard_meth, indication_heard_v,
    output indication_heard__RDY
  );

  modport slave (
    input  request_say__ENA, request_say_meth, request_say_v,
    output request_say__RDY,
    output indication_heard__ENA, indication_heard_meth, indication_heard_v,
    input  indication_heard__RDY
  );
endinterface

// File: rtl/echo_expect_fifo.sv
// DEPTH-entry FIFO of expected responses; head is visible without a pop so the
// incoming response can be compared in the same cycle it is accepted.
module echo_expect_fifo
  import echo_requester_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    CLK,
  input  logic    nRST,
  input  logic    clear,
  input  logic    push,
  input  logic    pop,
  input  expect_t push_data,
  output expect_t head,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW + 1)'(DEPTH);

  expect_t        mem [DEPTH];
  logic [AW-1:0]  wr_ptr_reg;
  logic [AW-1:0]  rd_ptr_reg;
  logic [AW:0]    occ_reg;

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ_reg <= occ_reg + 1'b1;
        2'b01:   occ_reg <= occ_reg - 1'b1;
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign full  = (occ_reg == FULL_OCC);
  assign empty = (occ_reg == '0);

endmodule

// File: rtl/echo_requester.sv
// Issues a numbered run of requests to an echo peer and scores each returned
// response against the record remembered when the request went out.
module echo_requester
  import echo_requester_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 start,
  input  logic [7:0]           count,
  input  logic [31:0]          base_v,
  echo_requester_if.master     bus,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           pass_count,
  output logic [7:0]           fail_count
);

  state_t      state_reg;
  logic [7:0]  count_reg;
  logic [31:0] base_reg;
  logic [7:0]  issued_reg;
  logic [7:0]  received_reg;
  logic [7:0]  pass_reg;
  logic [7:0]  fail_reg;

  expect_t     issue_rec;
  expect_t     head;
  logic        full;
  logic        empty;
  logic        issue;
  logic        accept;
  logic        rec_match;
  logic        clear_fifo;
  logic [7:0]  received_next;

  // Issue gating uses pre-pop occupancy: a full FIFO blocks issue even if a pop lands this cycle.
  assign issue      = (state_reg == RUN) && (issued_reg < count_reg) && !full
                      && bus.request_say__RDY;
  assign accept     = bus.indication_heard__ENA && bus.indication_heard__RDY;
  assign issue_rec  = make_expect(issued_reg, base_reg);
  assign rec_match  = (bus.indication_heard_meth == head.meth)
                      && (bus.indication_heard_v == head.v);
  assign clear_fifo = start && (state_reg != RUN);
  assign received_next = received_reg + 8'(accept);

  assign bus.request_say__ENA      = issue;
  assign bus.request_say_meth      = issue_rec.meth;
  assign bus.request_say_v         = issue_rec.v;
  assign bus.indication_heard__RDY = (state_reg == RUN) && !empty;

  echo_expect_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK       (CLK),
    .nRST      (nRST),
    .clear     (clear_fifo),
    .push      (issue),
    .pop       (accept),
    .push_data (issue_rec),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      base_reg     <= '0;
      issued_reg   <= '0;
      received_reg <= '0;
      pass_reg     <= '0;
      fail_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            count_reg    <= count;
            base_reg     <= base_v;
            issued_reg   <= '0;
            received_reg <= '0;
            pass_reg     <= '0;
            fail_reg     <= '0;
            state_reg    <= RUN;
          end
        end
        RUN: begin
          if (issue) begin
            issued_reg <= issued_reg + 8'd1;
          end
          if (accept) begin
            received_reg <= received_next;
            if (rec_match) begin
              pass_reg <= pass_reg + 8'd1;
            end else begin
              fail_reg <= fail_reg + 8'd1;
            end
          end
          // Also covers count == 0, which finishes on the first RUN cycle.
          if (received_next == count_reg) begin
            state_reg <= DONE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy       = (state_reg == RUN);
  assign done       = (state_reg == DONE);
  assign pass_count = pass_reg;
  assign fail_count = fail_reg;

endmodule

// File: tb/tb_echo_requester.sv
// Scoreboard bench for echo_requester: an echo model returns requests after a
// configurable delay, optionally corrupting one, and checks issue order.
module tb_echo_requester;
  import echo_requester_pkg::*;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        start;
  logic [7:0]  count;
  logic [31:0] base_v;
  logic        busy;
  logic        done;
  logic [7:0]  pass_count;
  logic [7:0]  fail_count;

  echo_requester_if bus();

  echo_requester #(.DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .start      (start),
    .count      (count),
    .base_v     (base_v),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .pass_count (pass_count),
    .fail_count (fail_count)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] meth;
    logic [31:0] v;
    int          due;
  } resp_t;

  expect_t req_q[$];
  resp_t   pipe_q[$];
  expect_t exp_rec;
  resp_t   resp_rec;
  int      cyc         = 0;
  bit      resp_en     = 1'b1;
  int      resp_delay  = 2;
  int      corrupt_idx = -1;
  int      resp_idx    = 0;
  int      issued_cnt  = 0;

  // Echo model: observes at the falling edge, so what it sees is what the next rising edge takes.
  initial begin : echo_model
    bus.indication_heard__ENA  = 1'b0;
    bus.indication_heard_meth  = '0;
    bus.indication_heard_v     = '0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (nRST !== 1'b1) begin
        req_q.delete();
        pipe_q.delete();
        bus.indication_heard__ENA = 1'b0;
      end else begin
        if (bus.request_say__ENA === 1'b1) begin
          check("ena_with_rdy", {31'd0, bus.request_say__RDY}, 32'd1);
          check("req_expected", {31'd0, req_q.size() != 0}, 32'd1);
          if (req_q.size() != 0) begin
            exp_rec = req_q.pop_front();
            check("req_meth", bus.request_say_meth, exp_rec.meth);
            check("req_v", bus.request_say_v, exp_rec.v);
          end
          $display("[TB] req  meth=%0d v=0x%0h", bus.request_say_meth, bus.request_say_v);
          resp_rec.meth = bus.request_say_meth;
          resp_rec.v    = bus.request_say_v;
          resp_rec.due  = cyc + resp_delay;
          pipe_q.push_back(resp_rec);
          issued_cnt++;
        end
        if (resp_en && pipe_q.size() != 0 && pipe_q[0].due <= cyc) begin
          bus.indication_heard__ENA = 1'b1;
          bus.indication_heard_meth = pipe_q[0].meth;
          bus.indication_heard_v    = (resp_idx == corrupt_idx) ? pipe_q[0].v + 32'd1 : pipe_q[0].v;
          if (bus.indication_heard__RDY === 1'b1) begin
            $display("[TB] resp meth=%0d v=0x%0h", bus.indication_heard_meth, bus.indication_heard_v);
            void'(pipe_q.pop_front());
            resp_idx++;
          end
        end else begin
          bus.indication_heard__ENA = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_start(input logic [7:0] n, input logic [31:0] b);
    expect_t e;
    start  = 1'b1;
    count  = n;
    base_v = b;
    for (int k = 0; k < int'(n); k++) begin
      e.meth = 32'(k);
      e.v    = b + 32'(k);
      req_q.push_back(e);
    end
    resp_idx   = 0;
    issued_cnt = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input string tag);
    for (int i = 0; i < max_cyc && done !== 1'b1; i++) tick();
    check(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_issued(input int n, input string tag);
    for (int i = 0; i < 100 && issued_cnt < n; i++) tick();
    check(tag, {31'd0, issued_cnt >= n}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_say_ena"},   {31'd0, bus.request_say__ENA}, 32'd0);
    check({pfx, "_say_meth"},  bus.request_say_meth, 32'd0);
    check({pfx, "_say_v"},     bus.request_say_v, 32'd0);
    check({pfx, "_heard_rdy"}, {31'd0, bus.indication_heard__RDY}, 32'd0);
    check({pfx, "_busy"},      {31'd0, busy}, 32'd0);
    check({pfx, "_done"},      {31'd0, done}, 32'd0);
    check({pfx, "_pass"},      {24'd0, pass_count}, 32'd0);
    check({pfx, "_fail"},      {24'd0, fail_count}, 32'd0);
  endtask

  int stall_issued;

  initial begin : main
    nRST   = 1'b0;
    start  = 1'b0;
    count  = '0;
    base_v = '0;
    bus.request_say__RDY = 1'b1;
    tick();
    tick();
    check_reset_outputs("rst");
    nRST = 1'b1;
    tick();

    // Basic run with a 2-cycle echo
    run_start(8'd3, 32'h10);
    check("t1_busy", {31'd0, busy}, 32'd1);
    wait_done(100, "t1_done");
    check("t1_pass", {24'd0, pass_count}, 32'd3);
    check("t1_fail", {24'd0, fail_count}, 32'd0);
    check("t1_issued", 32'(issued_cnt), 32'd3);
    check("t1_busy_end", {31'd0, busy}, 32'd0);

    // Second response corrupted
    corrupt_idx = 1;
    run_start(8'd2, 32'hA0);
    wait_done(100, "t2_done");
    check("t2_pass", {24'd0, pass_count}, 32'd1);
    check("t2_fail", {24'd0, fail_count}, 32'd1);
    corrupt_idx = -1;

    // Silent peer: issue stops at DEPTH outstanding
    resp_en = 1'b0;
    run_start(8'd10, 32'h200);
    repeat (30) tick();
    check("t3_outstanding", 32'(issued_cnt), 32'(DEPTH));
    check("t3_ena_low", {31'd0, bus.request_say__ENA}, 32'd0);
    check("t3_busy", {31'd0, busy}, 32'd1);
    check("t3_heard_rdy", {31'd0, bus.indication_heard__RDY}, 32'd1);
    resp_en = 1'b1;
    wait_done(300, "t3_done");
    check("t3_pass", {24'd0, pass_count}, 32'd10);
    check("t3_issued", 32'(issued_cnt), 32'd10);

    // Back-pressure on the request side mid-run
    resp_delay = 1;
    run_start(8'd8, 32'hFFFF_FFFE);
    wait_issued(2, "t4_reach2");
    bus.request_say__RDY = 1'b0;
    stall_issued = issued_cnt;
    repeat (5) tick();
    check("t4_stall", 32'(issued_cnt), 32'(stall_issued));
    bus.request_say__RDY = 1'b1;
    wait_done(200, "t4_done");
    check("t4_pass", {24'd0, pass_count}, 32'd8);
    check("t4_fail", {24'd0, fail_count}, 32'd0);

    // Empty run finishes two cycles after start
    run_start(8'd0, 32'h55);
    check("t5_done_early", {31'd0, done}, 32'd0);
    tick();
    check("t5_done", {31'd0, done}, 32'd1);
    check("t5_issued", 32'(issued_cnt), 32'd0);
    check("t5_pass", {24'd0, pass_count}, 32'd0);
    check("t5_fail", {24'd0, fail_count}, 32'd0);

    // Reset mid-run, then a clean rerun
    resp_delay = 2;
    run_start(8'd6, 32'h7000);
    wait_issued(3, "t6_reach3");
    nRST = 1'b0;
    tick();
    check_reset_outputs("t6_rst");
    nRST = 1'b1;
    tick();
    run_start(8'd6, 32'h7000);
    wait_done(200, "t6_done");
    check("t6_pass", {24'd0, pass_count}, 32'd6);
    check("t6_fail", {24'd0, fail_count}, 32'd0);
    check("t6_issued", 32'(issued_cnt), 32'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
